// File: rtl/shift_issue_stage.sv
// Two-stage valid/ready issue pipeline for RV32I SLL/SRL/SRA (register and immediate forms).
// S1 registers the decoded operands and S2 registers the selected barrel-shifter result.

module shifter_32_bit #(
  parameter int SHIFTER_MODE = 0  // 0 = logical left, 2 = logical right, 3 = arithmetic right
) (
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic [31:0] data_out
);

  generate
    if (SHIFTER_MODE == 0) begin : g_sll
      assign data_out = data_in << shamt;
    end else if (SHIFTER_MODE == 2) begin : g_srl
      assign data_out = data_in >> shamt;
    end else begin : g_sra
      assign data_out = $unsigned($signed(data_in) >>> shamt);
    end
  endgenerate

endmodule

module shift_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      rs1,
  input  logic [31:0]      rs2,
  input  logic [11:0]      imm,
  input  logic             use_imm,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  // Encodings match the shifter instance modes so mode_q selects the result directly.
  typedef enum logic [1:0] {
    MODE_SLL = 2'd0,
    MODE_SRL = 2'd2,
    MODE_SRA = 2'd3
  } mode_e;

  logic [4:0]  shamt_in;
  logic [6:0]  f7_in;
  mode_e       mode_in;
  logic        err_in;
  logic        unused_rs2_hi;

  logic        v1_q, v1_d;
  logic [31:0] rs1_q, rs1_d;
  logic [4:0]  shamt_q, shamt_d;
  mode_e       mode_q, mode_d;
  logic        err1_q, err1_d;

  logic        v2_q, v2_d;
  logic [31:0] data_q, data_d;
  logic        err2_q, err2_d;

  logic [CNT_W-1:0] count_q, count_d;

  logic        adv1, adv2;
  logic [31:0] sll_res, srl_res, sra_res;
  logic [31:0] sel_res;

  assign unused_rs2_hi = ^rs2[31:5];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mode_in  = MODE_SLL;
    err_in   = 1'b1;
    shamt_in = use_imm ? imm[4:0]  : rs2[4:0];
    f7_in    = use_imm ? imm[11:5] : funct7;
    if (funct3 == 3'b001 && f7_in == 7'b0000000) begin
      mode_in = MODE_SLL;
      err_in  = 1'b0;
    end else if (funct3 == 3'b101 && f7_in == 7'b0000000) begin
      mode_in = MODE_SRL;
      err_in  = 1'b0;
    end else if (funct3 == 3'b101 && f7_in == 7'b0100000) begin
      mode_in = MODE_SRA;
      err_in  = 1'b0;
    end
  end

  // Ready ripples back combinationally; there is no skid buffer.
  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  shifter_32_bit #(.SHIFTER_MODE(0)) u_sll (.data_in(rs1_q), .shamt(shamt_q), .data_out(sll_res));
  shifter_32_bit #(.SHIFTER_MODE(2)) u_srl (.data_in(rs1_q), .shamt(shamt_q), .data_out(srl_res));
  shifter_32_bit #(.SHIFTER_MODE(3)) u_sra (.data_in(rs1_q), .shamt(shamt_q), .data_out(sra_res));

  always_comb begin
    sel_res = 32'h0;
    if (!err1_q) begin
      case (mode_q)
        MODE_SLL: sel_res = sll_res;
        MODE_SRL: sel_res = srl_res;
        MODE_SRA: sel_res = sra_res;
        default:  sel_res = 32'h0;
      endcase
    end
  end

  always_comb begin
    v1_d    = v1_q;
    rs1_d   = rs1_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    err1_d  = err1_q;
    v2_d    = v2_q;
    data_d  = data_q;
    err2_d  = err2_q;
    count_d = count_q;

    // Flush kills both valids and blocks every data load; the last result stays visible.
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (adv1) v1_d = in_valid;
      if (in_valid && adv1) begin
        rs1_d   = rs1;
        shamt_d = shamt_in;
        mode_d  = mode_in;
        err1_d  = err_in;
      end
      if (adv2) v2_d = v1_q;
      if (v1_q && adv2) begin
        data_d = sel_res;
        err2_d = err1_q;
      end
    end

    if (v2_q && out_ready) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      rs1_q   <= 32'h0;
      shamt_q <= 5'd0;
      mode_q  <= MODE_SLL;
      err1_q  <= 1'b0;
      v2_q    <= 1'b0;
      data_q  <= 32'h0;
      err2_q  <= 1'b0;
      count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      v1_q    <= v1_d;
      rs1_q   <= rs1_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
      err1_q  <= err1_d;
      v2_q    <= v2_d;
      data_q  <= data_d;
      err2_q  <= err2_d;
      count_q <= count_d;
    end
  end

  assign out_valid = v2_q;
  assign out_data  = data_q;
  assign out_err   = err2_q;
  assign op_count  = count_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: latency, decode, streaming with backpressure,
// illegal encodings, flush and asynchronous reset.

module tb_shift_issue_stage;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [11:0] imm;
  logic        use_imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [15:0] op_count;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_issue_stage #(.CNT_W(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .use_imm   (use_imm),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .op_count  (op_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [11:0] im,
                       input logic ui, input logic [2:0] f3, input logic [6:0] f7);
    rs1     = a;
    rs2     = b;
    imm     = im;
    use_imm = ui;
    funct3  = f3;
    funct7  = f7;
  endtask

  // One isolated op with out_ready held: not visible after the first edge, visible after the second.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [11:0] im, input logic ui, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] exp_data, input logic exp_err);
    drive(a, b, im, ui, f3, f7);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check({tag, ".not_yet"}, {31'd0, out_valid}, 32'd0);
    tick();
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".data"}, out_data, exp_data);
    check({tag, ".err"}, {31'd0, out_err}, {31'd0, exp_err});
    tick();
    check({tag, ".drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [31:0] t_rs1 [8];
  logic [4:0]  t_sh  [8];
  logic [2:0]  t_f3  [8];
  logic [6:0]  t_f7  [8];
  logic [31:0] t_exp [8];

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(32'h0, 32'h0, 12'h0, 1'b0, 3'b000, 7'h00);

    // Stream table: SLL/SRL/SRA including shamt 0 and 31 and sign fill.
    t_rs1[0] = 32'h00000003; t_sh[0] = 5'd4;  t_f3[0] = 3'b001; t_f7[0] = 7'h00; t_exp[0] = 32'h00000030;
    t_rs1[1] = 32'hF0000000; t_sh[1] = 5'd8;  t_f3[1] = 3'b101; t_f7[1] = 7'h00; t_exp[1] = 32'h00F00000;
    t_rs1[2] = 32'hF0000000; t_sh[2] = 5'd8;  t_f3[2] = 3'b101; t_f7[2] = 7'h20; t_exp[2] = 32'hFFF00000;
    t_rs1[3] = 32'h12345678; t_sh[3] = 5'd0;  t_f3[3] = 3'b001; t_f7[3] = 7'h00; t_exp[3] = 32'h12345678;
    t_rs1[4] = 32'h7FFFFFFF; t_sh[4] = 5'd31; t_f3[4] = 3'b101; t_f7[4] = 7'h20; t_exp[4] = 32'h00000000;
    t_rs1[5] = 32'h80000001; t_sh[5] = 5'd31; t_f3[5] = 3'b101; t_f7[5] = 7'h20; t_exp[5] = 32'hFFFFFFFF;
    t_rs1[6] = 32'hDEADBEEF; t_sh[6] = 5'd16; t_f3[6] = 3'b101; t_f7[6] = 7'h00; t_exp[6] = 32'h0000DEAD;
    t_rs1[7] = 32'h0000ABCD; t_sh[7] = 5'd16; t_f3[7] = 3'b001; t_f7[7] = 7'h00; t_exp[7] = 32'hABCD0000;

    // Reset state
    #12;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_data", out_data, 32'h0);
    check("rst.out_err", {31'd0, out_err}, 32'd0);
    check("rst.op_count", {16'd0, op_count}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);

    // 1: SRA register form, two-edge latency
    run_op("sra", 32'h80000000, 32'h00000004, 12'h000, 1'b0, 3'b101, 7'h20, 32'hF8000000, 1'b0);
    check("sra.op_count", {16'd0, op_count}, 32'd1);

    // 2: SLLI shamt 31, SRL with upper rs2 bits set
    run_op("slli", 32'h00000001, 32'h0, 12'h01F, 1'b1, 3'b001, 7'h7F, 32'h80000000, 1'b0);
    run_op("srl31", 32'h80000000, 32'hFFFFFFFF, 12'h000, 1'b0, 3'b101, 7'h00, 32'h00000001, 1'b0);
    check("t2.op_count", {16'd0, op_count}, 32'd3);

    // 3: eight back-to-back bundles, out_ready pattern 1,0,0 repeating
    begin
      int tx = 0;
      int rx = 0;
      for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
        in_valid = (tx < 8);
        if (tx < 8) drive(t_rs1[tx], {27'h0055E6F, t_sh[tx]}, 12'h000, 1'b0, t_f3[tx], t_f7[tx]);
        out_ready = (cyc % 3 == 0);
        #1;
        if (out_valid && out_ready) begin
          check($sformatf("stream.data%0d", rx), out_data, t_exp[rx]);
          check($sformatf("stream.err%0d", rx), {31'd0, out_err}, 32'd0);
          rx++;
        end
        if (in_valid && in_ready) tx++;
        tick();
      end
      check("stream.received", rx, 32'd8);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("stream.no_dup", {31'd0, out_valid}, 32'd0);
      check("stream.op_count", {16'd0, op_count}, 32'd11);
    end

    // 4: illegal encodings still flow and count
    run_op("srli_bad", 32'hFFFFFFFF, 32'h0, 12'h023, 1'b1, 3'b101, 7'h00, 32'h00000000, 1'b1);
    run_op("sll_f7", 32'hFFFFFFFF, 32'h00000002, 12'h000, 1'b0, 3'b001, 7'h20, 32'h00000000, 1'b1);
    check("t4.op_count", {16'd0, op_count}, 32'd13);

    // 5: fill both stages under backpressure, then flush
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(32'h0000000F, 32'h00000004, 12'h000, 1'b0, 3'b001, 7'h00);  // -> 0x000000F0
    tick();
    drive(32'h000000F0, 32'h00000004, 12'h000, 1'b0, 3'b101, 7'h00);  // -> 0x0000000F
    tick();
    #1;
    check("full.in_ready", {31'd0, in_ready}, 32'd0);
    check("full.valid", {31'd0, out_valid}, 32'd1);
    check("full.data", out_data, 32'h000000F0);
    tick();
    check("held.data", out_data, 32'h000000F0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush.valid", {31'd0, out_valid}, 32'd0);
    check("flush.in_ready", {31'd0, in_ready}, 32'd1);
    check("flush.data_kept", out_data, 32'h000000F0);
    // A bundle offered during a flush cycle is dropped.
    drive(32'h00000001, 32'h00000001, 12'h000, 1'b0, 3'b001, 7'h00);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    check("flush.no_stale1", {31'd0, out_valid}, 32'd0);
    tick();
    check("flush.no_stale2", {31'd0, out_valid}, 32'd0);
    check("flush.op_count", {16'd0, op_count}, 32'd13);

    // 6: asynchronous reset with both stages valid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(32'h00000055, 32'h00000001, 12'h000, 1'b0, 3'b001, 7'h00);  // -> 0xAA
    tick();
    tick();
    check("pre_rst.valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst.data", out_data, 32'h000000AA);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst.valid", {31'd0, out_valid}, 32'd0);
    check("arst.data", out_data, 32'h0);
    check("arst.op_count", {16'd0, op_count}, 32'd0);
    in_valid = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
    run_op("post_rst", 32'hC0000000, 32'h00000002, 12'h000, 1'b0, 3'b101, 7'h20, 32'hF0000000, 1'b0);
    check("post_rst.op_count", {16'd0, op_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
